// File: rtl/snake_pkg.sv
// Shared constants, colour codes, FSM state type and the pixel-address helper
// for the snake game video path.
// No ports (package).
package snake_pkg;

    localparam int unsigned XSCREEN = 160;
    localparam int unsigned YSCREEN = 120;
    localparam int unsigned NPIX    = XSCREEN * YSCREEN;
    localparam int unsigned AW      = 15;

    localparam logic [2:0] BG    = 3'b000;
    localparam logic [2:0] APPLE = 3'b100;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StScan,
        StDrain,
        StDone
    } fsm_state_e;

    // y*160 + x as shifts so it maps to adders only.
    function automatic logic [AW-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        logic [AW-1:0] yy;
        yy = {8'b0, y};
        return (yy << 7) + (yy << 5) + {7'b0, x};
    endfunction

endpackage

// File: rtl/pixel_shadow_fb_if.sv
// Bundle for pixel_shadow_fb: pixel write stream (x/y/colour/plot), probe request
// (probe_start/probe_x/probe_y) and probe result (busy/done/hit/hit_colour).
// master: the draw/game side driving writes and probes. slave: the shadow buffer.
interface pixel_shadow_fb_if;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       probe_start;
    logic [7:0] probe_x;
    logic [6:0] probe_y;
    logic       busy;
    logic       done;
    logic       hit;
    logic [2:0] hit_colour;

    modport master (
        output x, y, colour, plot, probe_start, probe_x, probe_y,
        input  busy, done, hit, hit_colour
    );

    modport slave (
        input  x, y, colour, plot, probe_start, probe_x, probe_y,
        output busy, done, hit, hit_colour
    );
endinterface

// File: rtl/shadow_ram.sv
// Simple dual-port synchronous RAM for the shadow frame buffer.
// Ports: clk_i; write port we_i/waddr_i/wdata_i; read port raddr_i -> rdata_o
// (one-cycle latency, read-during-write returns the old word). No reset on contents.
module shadow_ram #(
    parameter int unsigned Depth = 19200,
    parameter int unsigned Width = 3,
    parameter int unsigned AddrW = 15
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);
    logic [Width-1:0] mem [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/pixel_shadow_fb.sv
// Shadow copy of the 160x120x3 frame buffer. Snoops the pixel write stream and
// answers box probes: is any pixel in an XDIM x YDIM box non-background, and the
// colour of the first such pixel in raster order.
// Ports: Clock, Reset (async, active high), bus (pixel_shadow_fb_if.slave).
// Build option: PIXEL_SHADOW_CLEAR_EN -- after reset, fill the RAM with BG
// (busy for 19200 cycles, external writes ignored meanwhile).
module pixel_shadow_fb
    import snake_pkg::*;
#(
    parameter int unsigned XDIM = 10,
    parameter int unsigned YDIM = 10
) (
    input  logic               Clock,
    input  logic               Reset,
    pixel_shadow_fb_if.slave   bus
);
    fsm_state_e    state_q, state_d;
    logic [7:0]    cx_q, cx_d, xc_q, xc_d;
    logic [6:0]    cy_q, cy_d, yc_q, yc_d;
    logic          rd_vld_q, rd_vld_d;
    logic          hit_q, hit_d;
    logic [2:0]    hcol_q, hcol_d;
`ifdef PIXEL_SHADOW_CLEAR_EN
    logic [AW-1:0] clr_q, clr_d;
`endif

    logic          we;
    logic [AW-1:0] waddr, raddr;
    logic [2:0]    wdata, rdata;
    logic [8:0]    px;
    logic [7:0]    py;
    logic          in_screen;

    shadow_ram #(.Depth(NPIX), .Width(3), .AddrW(AW)) u_ram (
        .clk_i   (Clock),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // Box pixel coordinates widened so edges past the screen do not wrap.
    assign px        = {1'b0, cx_q} + {1'b0, xc_q};
    assign py        = {1'b0, cy_q} + {1'b0, yc_q};
    assign in_screen = (px < 9'(XSCREEN)) && (py < 8'(YSCREEN));
    assign raddr     = in_screen ? pix_addr(px[7:0], py[6:0]) : '0;

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        xc_d     = xc_q;
        yc_d     = yc_q;
        rd_vld_d = 1'b0;
        hit_d    = hit_q;
        hcol_d   = hcol_q;
`ifdef PIXEL_SHADOW_CLEAR_EN
        clr_d    = clr_q;
`endif
        we    = bus.plot && (bus.x < 8'(XSCREEN)) && (bus.y < 7'(YSCREEN));
        waddr = pix_addr(bus.x, bus.y);
        wdata = bus.colour;

        // Off-screen reads were never flagged valid, so they count as BG.
        if (rd_vld_q && rdata != BG) begin
            hit_d = 1'b1;
            if (!hit_q) hcol_d = rdata;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.probe_start) begin
                    cx_d    = bus.probe_x;
                    cy_d    = bus.probe_y;
                    xc_d    = '0;
                    yc_d    = '0;
                    hit_d   = 1'b0;
                    hcol_d  = BG;
                    state_d = StScan;
                end
            end
            StScan: begin
                rd_vld_d = in_screen;
                if (xc_q == 8'(XDIM - 1)) begin
                    xc_d = '0;
                    if (yc_q == 7'(YDIM - 1)) begin
                        state_d = StDrain;
                    end else begin
                        yc_d = yc_q + 7'd1;
                    end
                end else begin
                    xc_d = xc_q + 8'd1;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            StClear: begin
`ifdef PIXEL_SHADOW_CLEAR_EN
                we    = 1'b1;
                waddr = clr_q;
                wdata = BG;
                if (clr_q == AW'(NPIX - 1)) begin
                    state_d = StIdle;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
`ifdef PIXEL_SHADOW_CLEAR_EN
            state_q <= StClear;
            clr_q   <= '0;
`else
            state_q <= StIdle;
`endif
            cx_q     <= '0;
            cy_q     <= '0;
            xc_q     <= '0;
            yc_q     <= '0;
            rd_vld_q <= 1'b0;
            hit_q    <= 1'b0;
            hcol_q   <= BG;
        end else begin
            state_q  <= state_d;
`ifdef PIXEL_SHADOW_CLEAR_EN
            clr_q    <= clr_d;
`endif
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            xc_q     <= xc_d;
            yc_q     <= yc_d;
            rd_vld_q <= rd_vld_d;
            hit_q    <= hit_d;
            hcol_q   <= hcol_d;
        end
    end

    assign bus.busy       = (state_q == StClear) || (state_q == StScan) || (state_q == StDrain);
    assign bus.done       = (state_q == StDone);
    assign bus.hit        = hit_q;
    assign bus.hit_colour = hcol_q;
endmodule

// File: tb/tb_pixel_shadow_fb.sv
// Scoreboard bench for pixel_shadow_fb: probes push the expected result and the
// accepting edge; a monitor pops on every done pulse and checks hit, colour and latency.
module tb_pixel_shadow_fb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_shadow_fb_if dif ();

    pixel_shadow_fb dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (dif)
    );

    typedef struct {
        logic        hit;
        logic [2:0]  col;
        int unsigned acc;
    } exp_t;

    exp_t        q [$];
    int unsigned edge_cnt = 0;
    int          vecs = 0;
    int          errs = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding probe.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (dif.done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("hit", {31'b0, dif.hit}, {31'b0, e.hit});
                chk("hit_colour", {29'b0, dif.hit_colour}, {29'b0, e.col});
                // Accepting edge n, done visible after edge n+101 (cycle 102).
                chk("done_latency", edge_cnt - e.acc, 32'd101);
            end
        end
    end

    task automatic plot_px(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        @(negedge clk);
        dif.x = x; dif.y = y; dif.colour = c; dif.plot = 1'b1;
        @(negedge clk);
        dif.plot = 1'b0;
    endtask

    task automatic start_probe(input logic [7:0] x, input logic [6:0] y,
                               input logic eh, input logic [2:0] ec);
        exp_t e;
        @(negedge clk);
        dif.probe_start = 1'b1; dif.probe_x = x; dif.probe_y = y;
        @(posedge clk);
        #1;
        dif.probe_start = 1'b0;
        e.hit = eh; e.col = ec; e.acc = edge_cnt;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((dif.busy !== 1'b0 || q.size() != 0) && n < 25000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'b0, n >= 25000}, 32'd0);
    endtask

    task automatic probe(input logic [7:0] x, input logic [6:0] y,
                         input logic eh, input logic [2:0] ec);
        start_probe(x, y, eh, ec);
        wait_idle();
    endtask

    initial begin
        dif.x = '0; dif.y = '0; dif.colour = '0; dif.plot = 1'b0;
        dif.probe_start = 1'b0; dif.probe_x = '0; dif.probe_y = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, dif.busy}, 32'd0);
        chk("rst_done", {31'b0, dif.done}, 32'd0);
        chk("rst_hit", {31'b0, dif.hit}, 32'd0);
        chk("rst_hit_colour", {29'b0, dif.hit_colour}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
`ifdef PIXEL_SHADOW_CLEAR_EN
        chk("clear_busy", {31'b0, dif.busy}, 32'd1);
`else
        chk("busy_after_release", {31'b0, dif.busy}, 32'd0);
`endif
        wait_idle();

        // Paint the whole screen with background.
        @(negedge clk);
        dif.colour = 3'b000;
        dif.plot = 1'b1;
        for (int yy = 0; yy < 120; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                dif.x = 8'(xx); dif.y = 7'(yy);
                @(negedge clk);
            end
        end
        dif.plot = 1'b0;

        // 1: apple inside box.
        plot_px(8'd30, 7'd30, 3'b100);
        probe(8'd25, 7'd25, 1'b1, 3'b100);
        repeat (5) @(negedge clk);
        chk("hit_held", {31'b0, dif.hit}, 32'd1);

        // 2: empty box; hit cleared on accept; a write while busy still lands.
        start_probe(8'd100, 7'd100, 1'b0, 3'b000);
        chk("hit_cleared_on_accept", {31'b0, dif.hit}, 32'd0);
        chk("busy_in_scan", {31'b0, dif.busy}, 32'd1);
        plot_px(8'd120, 7'd10, 3'b110);
        wait_idle();
        probe(8'd115, 7'd5, 1'b1, 3'b110);

        // 3: off-screen writes dropped; (0,116) aliases x=160,y=115 if the box wrapped.
        plot_px(8'd160, 7'd5, 3'b010);
        plot_px(8'd5, 7'd120, 3'b010);
        plot_px(8'd0, 7'd116, 3'b001);
        probe(8'd155, 7'd115, 1'b0, 3'b000);
        probe(8'd0, 7'd0, 1'b0, 3'b000);

        // Raster order: (52,50) precedes (50,51).
        plot_px(8'd52, 7'd50, 3'b011);
        plot_px(8'd50, 7'd51, 3'b101);
        probe(8'd50, 7'd50, 1'b1, 3'b011);

        // 4: second start while busy is ignored.
        start_probe(8'd25, 7'd25, 1'b1, 3'b100);
        repeat (8) @(negedge clk);
        dif.probe_start = 1'b1; dif.probe_x = 8'd100; dif.probe_y = 7'd100;
        @(posedge clk);
        #1;
        chk("busy_ignore_start", {31'b0, dif.busy}, 32'd1);
        dif.probe_start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);

        // 5: reset mid-probe, hit already set by the box corner pixel.
        start_probe(8'd30, 7'd30, 1'b1, 3'b100);
        repeat (48) @(negedge clk);
        q.delete();
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, dif.busy}, 32'd0);
        chk("midrst_done", {31'b0, dif.done}, 32'd0);
        chk("midrst_hit", {31'b0, dif.hit}, 32'd0);
        chk("midrst_hit_colour", {29'b0, dif.hit_colour}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        wait_idle();

`ifdef PIXEL_SHADOW_CLEAR_EN
        // 6: the apple at (30,30) was wiped by CLEAR.
        probe(8'd25, 7'd25, 1'b0, 3'b000);
`else
        // Without CLEAR the RAM survives reset.
        probe(8'd25, 7'd25, 1'b1, 3'b100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
